// File: rtl/gpu_pkg.sv
// Shared constants and loader state encoding for the instruction-memory writer.
// Latency: n/a (package).  Backpressure: n/a (package).
package gpu_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } ld_state_t;

    // Drop one byte into its little-endian lane of a partially assembled word.
    function automatic logic [INSTR_W-1:0] pack_byte(
        input logic [INSTR_W-1:0] word,
        input logic [1:0]         lane,
        input logic [7:0]         b
    );
        logic [INSTR_W-1:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and flags each completed word.
// Latency: word_valid pulses the cycle after byte 3 is accepted, with word_dat holding the word.
// Backpressure: none; the caller gates byte_vld with its own ready.
module byte_packer
    import gpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_vld,
    input  logic [7:0]         byte_dat,
    output logic               last_byte,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word_dat
);

    logic [1:0]         byte_cnt;
    logic [INSTR_W-1:0] asm_q;

    assign last_byte = byte_vld && (byte_cnt == 2'd3);
    assign word_dat  = asm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            asm_q      <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            byte_cnt   <= 2'd0;
            asm_q      <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= last_byte;
            if (byte_vld) begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_q    <= pack_byte(asm_q, byte_cnt, byte_dat);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a host byte stream into imem as 32-bit words and holds core_rst until done (IMEM_LOADER_CSUM_EN adds a checksum trailer).
// Latency: each word is written the cycle after its 4th byte; core_rst falls the cycle after DONE is entered.
// Backpressure: s_ready is high only in LOAD/CSUM; bytes offered at other times are not consumed.
module imem_loader
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W:0]    word_count,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               core_rst,
    output logic               err
);
    import gpu_pkg::*;

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("imem_loader: DEPTH must equal 2**ADDR_W");
    end
    if (INSTR_W != 32) begin : g_bad_width
        $error("imem_loader: INSTR_W must be 32");
    end

    ld_state_t         state_q, state_d;
    logic [ADDR_W:0]   wc_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              core_rst_d;
    logic              start_acc;
    logic              byte_vld;
    logic              pk_last;
    logic              pk_word_vld;
    logic [INSTR_W-1:0] pk_word;
    logic              final_word;

    assign s_ready    = (state_q == LOAD) || (state_q == CSUM);
    assign busy       = s_ready;
    assign done       = (state_q == DONE);
    assign byte_vld   = s_valid && s_ready;
    assign imem_addr  = wr_addr_q;
    assign imem_wdata = pk_word;
    // Index is one bit wider than the address so a count of DEPTH terminates.
    assign final_word = (word_idx_q + (ADDR_W+1)'(1)) == wc_q;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_acc),
        .byte_vld   (byte_vld),
        .byte_dat   (s_data),
        .last_byte  (pk_last),
        .word_valid (pk_word_vld),
        .word_dat   (pk_word)
    );

`ifdef IMEM_LOADER_CSUM_EN
    logic               err_q, err_d;
    logic               wr_instr_q;
    logic [INSTR_W-1:0] xor_q;

    assign err     = err_q;
    assign imem_we = pk_word_vld && wr_instr_q;
`else
    assign err     = 1'b0;
    assign imem_we = pk_word_vld;
`endif

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (word_count != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (pk_last && final_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end
            end
            CSUM: begin
                if (pk_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

`ifdef IMEM_LOADER_CSUM_EN
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (pk_word_vld && !wr_instr_q) begin
            err_d = (pk_word != xor_q);
        end
        core_rst_d = !((state_q == DONE) && (state_d == DONE) && !err_d);
`else
        core_rst_d = !((state_q == DONE) && (state_d == DONE));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            core_rst   <= 1'b1;
            wc_q       <= '0;
            word_idx_q <= '0;
            wr_addr_q  <= '0;
        end else begin
            state_q  <= state_d;
            core_rst <= core_rst_d;
            if (start_acc) begin
                wc_q       <= word_count;
                word_idx_q <= '0;
                wr_addr_q  <= '0;
            end else if (pk_last && (state_q == LOAD)) begin
                word_idx_q <= word_idx_q + (ADDR_W+1)'(1);
                wr_addr_q  <= word_idx_q[ADDR_W-1:0];
            end
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    // The checksum word goes through the packer like any other but is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            wr_instr_q <= 1'b0;
            xor_q      <= '0;
        end else begin
            err_q <= err_d;
            if (pk_last) wr_instr_q <= (state_q == LOAD);
            if (start_acc) begin
                xor_q <= '0;
            end else if (pk_word_vld && wr_instr_q) begin
                xor_q <= xor_q ^ pk_word;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven, popped on imem_we.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  word_count = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        core_rst;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_we  = -100;
    logic [39:0] exp_q[$];
    logic [39:0] exp_e;
    logic [31:0] tbl[2] = '{32'h12345678, 32'hDEADBEEF};

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .core_rst   (core_rst),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            check("we_gap", 32'(cyc - last_we >= 4), 32'd1);
            last_we = cyc;
            if (exp_q.size() == 0) begin
                check("unexp_we", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(exp_e[39:32]));
                check("wr_data", imem_wdata, exp_e[31:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok      = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = s_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) check("rdy_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall, input bit wr, input logic [7:0] addr);
        if (wr) exp_q.push_back({addr, w});
        for (int k = 0; k < 4; k++) begin
            if (stall) repeat ((k == 1) ? 2 : (k == 3) ? 1 : 0) tick();
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic start_load(input int cnt);
        start      = 1'b1;
        word_count = 9'(cnt);
        tick();
        start = 1'b0;
        if (cnt > 0) begin
            check("busy_start", 32'(busy), 32'd1);
            check("done_start", 32'(done), 32'd0);
            check("core_rst_start", 32'(core_rst), 32'd1);
        end
    endtask

    task automatic finish_load(input logic [31:0] x, input bit bad);
`ifdef IMEM_LOADER_CSUM_EN
        send_word(bad ? 32'h0 : x, 1'b0, 1'b0, 8'h0);
`else
        if (bad || (x == 32'h1)) tick();
`endif
        for (int n = 0; n < 200; n++) begin
            if (done) break;
            tick();
        end
        check("done", 32'(done), 32'd1);
        check("core_rst_first", 32'(core_rst), 32'd1);
        tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("core_rst_rel", 32'(core_rst), bad ? 32'd1 : 32'd0);
        check("err", 32'(err), bad ? 32'd1 : 32'd0);
    endtask

    task automatic run_load(input int cnt, input bit ramp, input bit stall, input bit bad);
        logic [31:0] x;
        logic [31:0] w;
        x = '0;
        start_load(cnt);
        for (int i = 0; i < cnt; i++) begin
            w = ramp ? 32'(i) : tbl[i % 2];
            x = x ^ w;
            send_word(w, stall, 1'b1, 8'(i));
        end
        finish_load(x, bad);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) tick();
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);

        // Zero-length load goes straight to DONE with no writes.
        start_load(0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_core_rst_first", 32'(core_rst), 32'd1);
        tick();
        check("zero_core_rst_rel", 32'(core_rst), 32'd0);

        // Two words back-to-back, restarted from DONE.
        run_load(2, 1'b0, 1'b0, 1'b0);

        // Same words with host stalls; a start pulse mid-load must be ignored.
        start_load(2);
        send_word(tbl[0], 1'b1, 1'b1, 8'd0);
        start      = 1'b1;
        word_count = 9'd1;
        tick();
        start = 1'b0;
        check("start_in_load_busy", 32'(busy), 32'd1);
        send_word(tbl[1], 1'b1, 1'b1, 8'd1);
        finish_load(tbl[0] ^ tbl[1], 1'b0);

        // Full-depth load; address must stop at 255 and never wrap.
        run_load(256, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        check("addr_hold", 32'(imem_addr), 32'd255);

        // Reset after byte 2 of word 1 aborts the load.
        start_load(2);
        send_word(tbl[0], 1'b0, 1'b1, 8'd0);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        rst = 1'b1;
        #2;
        check("abort_we", 32'(imem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_core_rst", 32'(core_rst), 32'd1);
        check("abort_s_ready", 32'(s_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) tick();
        check("abort_done", 32'(done), 32'd0);
        check("abort_sb", 32'(exp_q.size()), 32'd0);
        run_load(1, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
        // Bad checksum keeps the core in reset; the next start clears err.
        run_load(2, 1'b0, 1'b0, 1'b1);
        tick();
        check("bad_core_rst_hold", 32'(core_rst), 32'd1);
        start_load(0);
        check("err_clear", 32'(err), 32'd0);
`endif

        repeat (5) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
